// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI SRAM read engine.
// Beat bundle, burst encoding and response codes.
package axi_rd_pkg;

  localparam int IDS_W  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;
  localparam int MEM_AW = 14;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [IDS_W-1:0]  id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  // Wrap windows must be a power-of-two number of beats, 2..16
  function automatic logic wrap_ok(
    input logic [LEN_W-1:0] len
  );
    return (len != '0) &&
           ((len & (len + 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry R-beat buffer absorbing RREADY stalls.
// Head is registered, so outputs hold while not popped.
module rd_skid_fifo
  import axi_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rbeat_t     din,
  input  logic       pop,
  output rbeat_t     dout,
  output logic [1:0] count
);

  rbeat_t     ent [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push &&
                   ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        ent[wr_q] <= din;
        wr_q      <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = ent[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/axi_sram_rd_engine.sv
// AXI read slave: one AR burst at a time, beats fetched
// from a 1-cycle SRAM and returned through a 2-entry buffer.
module axi_sram_rd_engine
  import axi_rd_pkg::*;
#(
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  ARID_S,
  input  logic [ADDR_W-1:0] ARADDR_S,
  input  logic [LEN_W-1:0]  ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [IDS_W-1:0]  RID_S,
  output logic [DATA_W-1:0] RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  output logic              mem_cs,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDS_W-1:0]  id_q;
  logic [MEM_AW-1:0] addr_q;
  logic [MEM_AW-1:0] addr_nxt;
  logic [MEM_AW-1:0] addr_inc;
  logic [MEM_AW-1:0] wmask;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  burst_t            burst_q;

  logic             pipe_v_q;
  logic [IDS_W-1:0] pipe_id_q;
  logic             pipe_last_q;
  logic             pipe_rsvd_q;

  logic       arready;
  logic       issue;
  logic       credit;
  logic       is_last;
  logic       ar_hs;
  logic       pop;
  logic [2:0] occ;
  logic [1:0] fifo_cnt;
  rbeat_t     beat_in;
  rbeat_t     head;

  logic unused_bits;
  assign unused_bits = ^{ARSIZE_S,
                         ARADDR_S[ADDR_W-1:MEM_AW+2],
                         ARADDR_S[1:0]};

  assign ar_hs   = ARVALID_S && arready;
  assign pop     = RVALID_S && RREADY_S;
  assign is_last = (cnt_q == len_q);

  // Buffered plus in-flight beats, net of this cycle's pop
  assign occ    = {1'b0, fifo_cnt} + {2'b00, pipe_v_q};
  assign credit = occ < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ar_hs) state_d = S_BURST;
      S_BURST: if (issue && is_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE:  arready = rst;
      S_BURST: issue   = credit;
      default: ;
    endcase
  end

  assign addr_inc = addr_q + 1'b1;
  assign wmask    = {{(MEM_AW-LEN_W){1'b0}}, len_q};

  always_comb begin
    addr_nxt = addr_inc;
    unique case (burst_q)
      FIXED: addr_nxt = addr_q;
      WRAP: begin
        if (wrap_ok(len_q))
          addr_nxt = (addr_q & ~wmask) |
                     (addr_inc & wmask);
      end
      default: addr_nxt = addr_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= INCR;
    end else if (ar_hs) begin
      id_q    <= ARID_S;
      addr_q  <= ARADDR_S[MEM_AW+1:2];
      len_q   <= ARLEN_S;
      cnt_q   <= '0;
      burst_q <= burst_t'(ARBURST_S);
    end else if (issue) begin
      addr_q <= addr_nxt;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Metadata travels alongside the SRAM read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v_q    <= 1'b0;
      pipe_id_q   <= '0;
      pipe_last_q <= 1'b0;
      pipe_rsvd_q <= 1'b0;
    end else begin
      pipe_v_q <= issue;
      if (issue) begin
        pipe_id_q   <= id_q;
        pipe_last_q <= is_last;
        pipe_rsvd_q <= (burst_q == RSVD);
      end
    end
  end

  always_comb begin
    beat_in.id   = pipe_id_q;
    beat_in.data = pipe_rsvd_q ? '0 : mem_rdata;
    beat_in.resp = pipe_rsvd_q ? RESP_SLVERR
                               : RESP_OKAY;
    beat_in.last = pipe_last_q;
  end

  rd_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_v_q),
    .din   (beat_in),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt)
  );

  assign ARREADY_S = arready;
  assign mem_cs    = issue && (burst_q != RSVD);
  assign mem_addr  = addr_q;
  assign RVALID_S  = (fifo_cnt != 2'd0);
  assign RID_S     = head.id;
  assign RDATA_S   = head.data;
  assign RRESP_S   = head.resp;
  assign RLAST_S   = head.last;

endmodule

// File: tb/tb_axi_sram_rd_engine.sv
// Directed bench for axi_sram_rd_engine with an
// expected-beat scoreboard and a behavioural SRAM.
module tb_axi_sram_rd_engine;
  import axi_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ARID_S = '0;
  logic [31:0] ARADDR_S = '0;
  logic [3:0]  ARLEN_S = '0;
  logic [2:0]  ARSIZE_S = 3'b010;
  logic [1:0]  ARBURST_S = '0;
  logic        ARVALID_S = 1'b0;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S = 1'b1;
  logic        mem_cs;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  axi_sram_rd_engine dut (
    .clk       (clk),
    .rst       (rst_n),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [0:16383];

  always @(posedge clk)
    if (mem_cs) mem_rdata <= mem[mem_addr];

  int     n_assert = 0;
  int     n_fail = 0;
  rbeat_t exp_q[$];
  int     addr_q[$];
  int     cs_cyc[$];
  int     pop_cyc[$];
  int     cyc = 0;
  int     out_cnt = 0;
  int     cs_total = 0;
  bit     chk_credit = 0;
  bit     held_v = 0;
  rbeat_t held;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int nxt(int a, int len, int b);
    if (b == 0) return a;
    if (b == 2 && (len == 1 || len == 3 ||
                   len == 7 || len == 15))
      return (a & ~len) | ((a + 1) & len);
    return (a + 1) % 16384;
  endfunction

  always @(negedge clk) begin
    logic   p;
    rbeat_t cur;
    cyc++;
    if (rst_n) begin
      p   = RVALID_S && RREADY_S;
      cur = {RID_S, RDATA_S, RRESP_S, RLAST_S};
      if (mem_cs) begin
        cs_total++;
        cs_cyc.push_back(cyc);
        if (addr_q.size() == 0)
          chk("cs_unexpected", 1, 0);
        else
          chk("mem_addr", 64'(mem_addr),
              64'(addr_q.pop_front()));
        if (chk_credit)
          chk("credit",
              64'((out_cnt - int'(p)) < 2), 1);
      end
      if (RVALID_S && held_v)
        chk("stable", 64'(cur), 64'(held));
      if (p) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0)
          chk("beat_unexpected", 1, 0);
        else
          chk("beat", 64'(cur),
              64'(exp_q.pop_front()));
      end
      held_v = RVALID_S && !RREADY_S;
      held   = cur;
      out_cnt += int'(mem_cs) - int'(p);
    end else begin
      held_v = 0;
    end
  end

  task automatic expect_burst(input [7:0] id,
                              input [31:0] addr,
                              input [3:0] len,
                              input [1:0] b);
    int     a;
    rbeat_t e;
    a = int'(addr[15:2]);
    for (int i = 0; i <= int'(len); i++) begin
      if (b != 2'b11) addr_q.push_back(a);
      e.id   = id;
      e.data = (b == 2'b11) ? 32'h0 : mem[a];
      e.resp = (b == 2'b11) ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      exp_q.push_back(e);
      a = nxt(a, int'(len), int'(b));
    end
  endtask

  task automatic send_ar(input [7:0] id,
                         input [31:0] addr,
                         input [3:0] len,
                         input [1:0] b);
    bit ok;
    expect_burst(id, addr, len, b);
    @(posedge clk); #1;
    ARID_S    = id;
    ARADDR_S  = addr;
    ARLEN_S   = len;
    ARBURST_S = b;
    ARVALID_S = 1'b1;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ARREADY_S) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
  endtask

  task automatic drain(input bit bp);
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      if (bp) RREADY_S = (k % 4 == 0) || (k % 4 == 3);
    end
    chk("drain", 64'(ok), 1);
    @(posedge clk); #1;
    RREADY_S = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0;
    for (int i = 0; i < 16384; i++)
      mem[i] = {16'hBEEF ^ 16'(i), 16'(i)};
    mem[16] = 32'h0000A5A5;

    #12;
    chk("rst_arready", 64'(ARREADY_S), 0);
    chk("rst_rvalid", 64'(RVALID_S), 0);
    chk("rst_rlast", 64'(RLAST_S), 0);
    chk("rst_rid", 64'(RID_S), 0);
    chk("rst_rdata", 64'(RDATA_S), 0);
    chk("rst_rresp", 64'(RRESP_S), 0);
    chk("rst_mem_cs", 64'(mem_cs), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single beat with explicit latency
    expect_burst(8'h15, 32'h40, 4'd0, 2'b01);
    @(posedge clk); #1;
    ARID_S = 8'h15;
    ARADDR_S = 32'h40;
    ARLEN_S = 4'd0;
    ARBURST_S = 2'b01;
    ARVALID_S = 1'b1;
    @(negedge clk);
    chk("single_arready", 64'(ARREADY_S), 1);
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
    @(negedge clk);
    chk("single_cs_c1", 64'(mem_cs), 1);
    @(negedge clk);
    chk("single_rv_c2", 64'(RVALID_S), 0);
    @(negedge clk);
    chk("single_rv_c3", 64'(RVALID_S), 1);
    chk("single_data", 64'(RDATA_S), 64'h0000A5A5);
    chk("single_last", 64'(RLAST_S), 1);
    chk("single_id", 64'(RID_S), 64'h15);
    chk("single_resp", 64'(RRESP_S), 0);
    drain(0);

    // INCR len=3, back-to-back timing
    cs_cyc.delete();
    pop_cyc.delete();
    send_ar(8'h22, 32'h0, 4'd3, 2'b01);
    drain(0);
    chk("incr_ncs", 64'(cs_cyc.size()), 4);
    chk("incr_npop", 64'(pop_cyc.size()), 4);
    if (cs_cyc.size() == 4 && pop_cyc.size() == 4) begin
      chk("incr_cs_b2b", 64'(cs_cyc[3] - cs_cyc[0]), 3);
      chk("incr_pop_b2b", 64'(pop_cyc[3] - pop_cyc[0]), 3);
    end

    // backpressure INCR len=7
    out_cnt = 0;
    chk_credit = 1;
    send_ar(8'h31, 32'h80, 4'd7, 2'b01);
    drain(1);
    chk_credit = 0;

    // WRAP then FIXED queued behind it
    send_ar(8'h44, 32'h18, 4'd3, 2'b10);
    send_ar(8'h45, 32'h8, 4'd2, 2'b00);
    drain(0);

    // WRAP with illegal len behaves as INCR
    send_ar(8'h46, 32'h1C, 4'd2, 2'b10);
    drain(0);

    // reserved burst
    cs0 = cs_total;
    pop_cyc.delete();
    send_ar(8'h5A, 32'h300, 4'd1, 2'b11);
    drain(0);
    chk("rsvd_no_cs", 64'(cs_total - cs0), 0);
    if (pop_cyc.size() == 2)
      chk("rsvd_b2b", 64'(pop_cyc[1] - pop_cyc[0]), 1);
    else
      chk("rsvd_npop", 64'(pop_cyc.size()), 2);

    // reset mid-burst
    send_ar(8'h3C, 32'h100, 4'd7, 2'b01);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_q.size() <= 7) break;
    end
    chk("pre_rst_pop", 64'(exp_q.size()), 7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(RVALID_S), 0);
    chk("mid_rst_mem_cs", 64'(mem_cs), 0);
    chk("mid_rst_arready", 64'(ARREADY_S), 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 64'(ARREADY_S), 1);
    send_ar(8'h42, 32'h200, 4'd1, 2'b01);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
